// File: rtl/sd_pkg.sv
// Constants shared by the SPI-mode SD command serializer and the response receiver:
// FSM encoding, response lengths and R1 bit positions.
package sd_pkg;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_SHIFT      = 2'd2,
        S_DONE       = 2'd3
    } sd_state_e;

    localparam int R1_BITS = 8;
    localparam int R7_BITS = 40;

    localparam int R1_IDLE          = 0;
    localparam int R1_ERASE_RESET   = 1;
    localparam int R1_ILLEGAL_CMD   = 2;
    localparam int R1_CRC_ERR       = 3;
    localparam int R1_ERASE_SEQ_ERR = 4;
    localparam int R1_ADDR_ERR      = 5;
    localparam int R1_PARAM_ERR     = 6;

    // Bit 7 is the start bit and bit 0 only reports the idle state; neither is an error.
    localparam logic [7:0] R1_ERR_MASK = 8'((1 << R1_ERASE_RESET) | (1 << R1_ILLEGAL_CMD) |
                                            (1 << R1_CRC_ERR) | (1 << R1_ERASE_SEQ_ERR) |
                                            (1 << R1_ADDR_ERR) | (1 << R1_PARAM_ERR));

    function automatic logic r1_is_error(input logic [7:0] r1_val);
        return (r1_val & R1_ERR_MASK) != 8'h00;
    endfunction

endpackage

// File: rtl/sd_shift_in.sv
// MSB-first serial-in shift register with synchronous clear and enable.
// Exposes the next-state value so the caller can capture a word on the edge that completes it.
module sd_shift_in #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         din_i,
    output logic [W-1:0] shift_d_o
);

    logic [W-1:0] shift_q;
    logic [W-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (clr_i) begin
            shift_d = '0;
        end else if (en_i) begin
            shift_d = {shift_q[W-2:0], din_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign shift_d_o = shift_d;

endmodule

// File: rtl/sd_resp_rx.sv
// SPI-mode SD response receiver: waits for the R1 start bit on DO, shifts in R1 or R3/R7.
//  state        | meaning
//  S_IDLE       | waiting for an arm (isStart high)
//  S_WAIT_START | sampling DO for the first 0, counting the NCR window
//  S_SHIFT      | shifting response bits in, MSB first
//  S_DONE       | result valid; wait for isStart to drop
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX   = 64,
    parameter int LONG_BITS = R7_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        isStart,
    input  logic        isLong,
    input  logic        DO,
    output logic        isBusy,
    output logic        isFinish,
    output logic        isTimeout,
    output logic [7:0]  r1,
    output logic [31:0] payload,
    output logic        isError
);

    localparam logic [7:0] NCR_LIMIT  = 8'(NCR_MAX);
    localparam logic [5:0] LONG_LIMIT = 6'(LONG_BITS);
    localparam logic [5:0] R1_LIMIT   = 6'(R1_BITS);

    sd_state_e             state_q, state_d;
    logic                  long_q, long_d;
    logic [7:0]            wait_q, wait_d, wait_inc;
    logic [5:0]            bit_q, bit_d, bit_inc, bit_target;
    logic                  timeout_q, timeout_d;
    logic [7:0]            r1_q, r1_d;
    logic [31:0]           payload_q, payload_d;
    logic                  error_q, error_d;
    logic                  sh_clr, sh_en;
    logic [LONG_BITS-1:0]  sh_nxt;

    sd_shift_in #(.W(LONG_BITS)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (sh_clr),
        .en_i      (sh_en),
        .din_i     (DO),
        .shift_d_o (sh_nxt)
    );

    assign wait_inc   = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    assign bit_inc    = bit_q + 6'd1;
    assign bit_target = long_q ? LONG_LIMIT : R1_LIMIT;

    always_comb begin
        state_d   = state_q;
        long_d    = long_q;
        wait_d    = wait_q;
        bit_d     = bit_q;
        timeout_d = timeout_q;
        r1_d      = r1_q;
        payload_d = payload_q;
        error_d   = error_q;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (isStart) begin
                    long_d    = isLong;
                    wait_d    = 8'd0;
                    bit_d     = 6'd0;
                    sh_clr    = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                // A start bit on the same edge the window expires still counts as a start.
                if (!DO) begin
                    sh_en   = 1'b1;
                    bit_d   = 6'd1;
                    state_d = S_SHIFT;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == NCR_LIMIT) begin
                        timeout_d = 1'b1;
                        r1_d      = 8'hFF;
                        payload_d = 32'h0;
                        error_d   = r1_is_error(8'hFF);
                        state_d   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                sh_en = 1'b1;
                bit_d = bit_inc;
                if (bit_inc == bit_target) begin
                    r1_d      = long_q ? sh_nxt[LONG_BITS-1 -: 8] : sh_nxt[7:0];
                    payload_d = long_q ? sh_nxt[31:0] : 32'h0;
                    error_d   = r1_is_error(r1_d);
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (!isStart) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            long_q    <= 1'b0;
            wait_q    <= 8'd0;
            bit_q     <= 6'd0;
            timeout_q <= 1'b0;
            r1_q      <= 8'hFF;
            payload_q <= 32'h0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            long_q    <= long_d;
            wait_q    <= wait_d;
            bit_q     <= bit_d;
            timeout_q <= timeout_d;
            r1_q      <= r1_d;
            payload_q <= payload_d;
            error_q   <= error_d;
        end
    end

    assign isBusy    = (state_q == S_WAIT_START) || (state_q == S_SHIFT);
    assign isFinish  = (state_q == S_DONE);
    assign isTimeout = timeout_q;
    assign r1        = r1_q;
    assign payload   = payload_q;
    assign isError   = error_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx: R1, R7, timeout, error flag, async reset and NCR tie.
module tb_sd_resp_rx;

    logic        clk;
    logic        rst;
    logic        isStart;
    logic        isLong;
    logic        DO;
    logic        isBusy;
    logic        isFinish;
    logic        isTimeout;
    logic [7:0]  r1;
    logic [31:0] payload;
    logic        isError;

    int passed = 0;
    int total  = 0;

    sd_resp_rx #(.NCR_MAX(64), .LONG_BITS(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .isStart   (isStart),
        .isLong    (isLong),
        .DO        (DO),
        .isBusy    (isBusy),
        .isFinish  (isFinish),
        .isTimeout (isTimeout),
        .r1        (r1),
        .payload   (payload),
        .isError   (isError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic long_sel);
        isStart = 1'b1;
        isLong  = long_sel;
        DO      = 1'b1;
        tick();
    endtask

    task automatic send_bits(input logic [39:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            DO = v[i];
            tick();
        end
        DO = 1'b1;
    endtask

    task automatic idle_high(input int n);
        DO = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic release_start();
        isStart = 1'b0;
        DO      = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; isStart = 1'b0; isLong = 1'b0; DO = 1'b1;
        #12;
        total++; if ({isBusy, isFinish, isTimeout, isError} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {isBusy, isFinish, isTimeout, isError}); else passed++;
        total++; if (r1 !== 8'hFF) $display("FAIL reset_r1 got %h want ff", r1); else passed++;
        total++; if (payload !== 32'h0) $display("FAIL reset_payload got %h want 0", payload); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_r1_basic();
        arm(1'b0);
        total++; if (isBusy !== 1'b1) $display("FAIL r1_busy_after_arm got %b want 1", isBusy); else passed++;
        idle_high(3);
        send_bits(40'h01, 7, 1);
        total++; if (isFinish !== 1'b0) $display("FAIL r1_early_finish got %b want 0", isFinish); else passed++;
        send_bits(40'h01, 0, 0);
        total++; if ({isFinish, isBusy} !== 2'b10) $display("FAIL r1_finish got %b want 10", {isFinish, isBusy}); else passed++;
        total++; if (r1 !== 8'h01) $display("FAIL r1_value got %h want 01", r1); else passed++;
        total++; if ({isError, isTimeout} !== 2'b00) $display("FAIL r1_err_to got %b want 00", {isError, isTimeout}); else passed++;
        total++; if (payload !== 32'h0) $display("FAIL r1_payload got %h want 0", payload); else passed++;
        release_start();
        total++; if (isFinish !== 1'b0) $display("FAIL r1_finish_drop got %b want 0", isFinish); else passed++;
    endtask

    task automatic test_r7();
        logic [39:0] v;
        v = 40'h01_000001AA;
        arm(1'b1);
        send_bits(v, 39, 1);
        total++; if (isFinish !== 1'b0) $display("FAIL r7_early_finish got %b want 0", isFinish); else passed++;
        send_bits(v, 0, 0);
        total++; if (isFinish !== 1'b1) $display("FAIL r7_finish got %b want 1", isFinish); else passed++;
        total++; if (r1 !== 8'h01) $display("FAIL r7_r1 got %h want 01", r1); else passed++;
        total++; if (payload !== 32'h000001AA) $display("FAIL r7_payload got %h want 000001aa", payload); else passed++;
        total++; if (isError !== 1'b0) $display("FAIL r7_error got %b want 0", isError); else passed++;
        release_start();
        total++; if (payload !== 32'h000001AA) $display("FAIL r7_payload_hold got %h want 000001aa", payload); else passed++;
    endtask

    task automatic test_async_reset();
        logic [39:0] v;
        v = 40'hFF_FFFFFFFF;
        v[39] = 1'b0;
        arm(1'b1);
        send_bits(v, 39, 20);
        total++; if (isBusy !== 1'b1) $display("FAIL arst_busy_before got %b want 1", isBusy); else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++; if ({isBusy, isFinish, isTimeout, isError} !== 4'b0000) $display("FAIL arst_flags got %b want 0000", {isBusy, isFinish, isTimeout, isError}); else passed++;
        total++; if (r1 !== 8'hFF) $display("FAIL arst_r1 got %h want ff", r1); else passed++;
        total++; if (payload !== 32'h0) $display("FAIL arst_payload got %h want 0", payload); else passed++;
        isStart = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        arm(1'b0);
        send_bits(40'h00, 7, 0);
        total++; if (isFinish !== 1'b1) $display("FAIL arst_r1_finish got %b want 1", isFinish); else passed++;
        total++; if (r1 !== 8'h00) $display("FAIL arst_r1_value got %h want 00", r1); else passed++;
        release_start();
    endtask

    task automatic test_timeout();
        arm(1'b0);
        idle_high(63);
        total++; if ({isBusy, isFinish} !== 2'b10) $display("FAIL to_before got %b want 10", {isBusy, isFinish}); else passed++;
        idle_high(1);
        total++; if ({isFinish, isTimeout} !== 2'b11) $display("FAIL to_flags got %b want 11", {isFinish, isTimeout}); else passed++;
        total++; if (r1 !== 8'hFF) $display("FAIL to_r1 got %h want ff", r1); else passed++;
        total++; if (payload !== 32'h0) $display("FAIL to_payload got %h want 0", payload); else passed++;
        release_start();
        total++; if ({isBusy, isFinish} !== 2'b00) $display("FAIL to_idle got %b want 00", {isBusy, isFinish}); else passed++;
        total++; if (isTimeout !== 1'b1) $display("FAIL to_hold got %b want 1", isTimeout); else passed++;
    endtask

    task automatic test_error_hold();
        int stuck;
        arm(1'b0);
        total++; if (isTimeout !== 1'b0) $display("FAIL err_to_clear got %b want 0", isTimeout); else passed++;
        send_bits(40'h05, 7, 0);
        total++; if (isFinish !== 1'b1) $display("FAIL err_finish got %b want 1", isFinish); else passed++;
        total++; if (r1 !== 8'h05) $display("FAIL err_r1 got %h want 05", r1); else passed++;
        total++; if (isError !== 1'b1) $display("FAIL err_flag got %b want 1", isError); else passed++;
        stuck = 0;
        DO = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (isFinish !== 1'b1 || isBusy !== 1'b0) stuck++;
        end
        DO = 1'b1;
        total++; if (stuck !== 0) $display("FAIL err_hold_done got %0d bad cycles want 0", stuck); else passed++;
        release_start();
        total++; if (isFinish !== 1'b0) $display("FAIL err_release got %b want 0", isFinish); else passed++;
        arm(1'b0);
        total++; if (isBusy !== 1'b1) $display("FAIL err_rearm got %b want 1", isBusy); else passed++;
        send_bits(40'h00, 7, 0);
        total++; if ({isFinish, isError} !== 2'b10) $display("FAIL err_rearm_r1 got %b want 10", {isFinish, isError}); else passed++;
        release_start();
    endtask

    task automatic test_ncr_tie();
        arm(1'b0);
        idle_high(63);
        DO = 1'b0;
        tick();
        total++; if ({isBusy, isFinish} !== 2'b10) $display("FAIL tie_start got %b want 10", {isBusy, isFinish}); else passed++;
        send_bits(40'h00, 6, 0);
        total++; if ({isFinish, isTimeout} !== 2'b10) $display("FAIL tie_flags got %b want 10", {isFinish, isTimeout}); else passed++;
        total++; if (r1 !== 8'h00) $display("FAIL tie_r1 got %h want 00", r1); else passed++;
        release_start();
    endtask

    initial begin
        test_reset();
        test_r1_basic();
        test_r7();
        test_async_reset();
        test_timeout();
        test_error_hold();
        test_ncr_tie();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sd_resp_rx.md
Name: sd_resp_rx

Overview:
- Receives the SPI-mode SD card response on the card's DO line, downstream of the command serializer that drives DI.
- After the command frame is sent, the controller arms this block. It then waits for the card's first 0 bit, which is the R1 start. It shifts in an 8-bit R1 or a 40-bit R3/R7 response and reports the result, or a timeout.
- Both the command serializer and this block advance one bit per clk.

Parameters:
- NCR_MAX, 64, maximum clk cycles spent waiting for a start bit before timeout (legal range 1 to 255).
- LONG_BITS, 40, total length of an R3/R7 response in bits. R1 alone is 8 bits.

Ports:
- clk  input  1  system clock; DO is sampled on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- isStart  input  1  arm request, level-held by the controller until isFinish is seen.
- isLong  input  1  sampled when armed: 1 means R3/R7 (40 bits), 0 means R1 (8 bits).
- DO  input  1  serial data from the card, idle high.
- isBusy  output  1  high from arm until DONE.
- isFinish  output  1  high in DONE; held until isStart drops.
- isTimeout  output  1  valid while isFinish is high; 1 means no start bit was seen.
- r1  output  8  received R1 byte.
- payload  output  32  trailing 32 bits of R3/R7, MSB first. Zero for R1.
- isError  output  1  OR of r1[6:1], valid while isFinish is high.

Behaviour:
- Reset (async, rst=1): state=IDLE. isBusy=0, isFinish=0, isTimeout=0, isError=0, r1=8'hFF, payload=0, all counters=0. Reset mid-operation abandons the transfer immediately.
- IDLE:
  - Entered when isStart=1 is seen on a clk edge.
  - On that edge: latch isLong, clear the wait counter, clear the shift register, set isBusy=1. Go to WAIT_START.
  - The first DO sample is taken on the next edge.
- WAIT_START:
  - DO=1: increment the wait counter.
  - Counter reaches NCR_MAX with DO still 1: set isTimeout=1, r1=8'hFF, payload=0. Go to DONE.
  - DO=0: this is r1[7], the R1 start bit. Shift it in, set bit counter=1, go to SHIFT. DO=0 on the very first sampled cycle is legal (zero-latency card).
  - Tie rule: if the counter reaches NCR_MAX on the same edge that DO=0 is seen, DO=0 wins.
- SHIFT:
  - Each clk, shift DO in MSB-first and increment the bit counter.
  - When the counter reaches 8 (R1) or LONG_BITS (long), on that same edge: load r1 from the upper 8 bits, load payload from the lower 32 bits (long only), compute isError. Go to DONE.
  - Latency from start bit to isFinish: 8 clk (R1) or 40 clk (long).
- DONE:
  - isBusy=0, isFinish=1. Outputs are stable.
  - When isStart=0 is seen, go to IDLE. isFinish falls the cycle after.
  - If isStart is still 1, stay in DONE. A re-arm requires isStart to go low for at least one cycle.
- isStart dropping while in WAIT_START or SHIFT: ignored. Operation completes normally. The controller must not do this; this rule keeps the block deterministic if it does.
- Result outputs (r1, payload, isError, isTimeout) hold their last values through IDLE. They are updated only on entry to DONE. isTimeout clears on the next arm.
- Counters:
  - Wait counter: 8 bits, saturating.
  - Bit counter: 6 bits, never wraps because LONG_BITS is at most 63.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding (IDLE=0, WAIT_START=1, SHIFT=2, DONE=3);
  - R1_BITS=8 and R7_BITS=40;
  - R1 bit-position constants (IDLE=0, ILLEGAL_CMD=2, CRC_ERR=3, etc.), shared with the command serializer for the CMD8/CMD58 flows.
- No sub-module needed. One optional helper, sd_shift_in, holds the 40-bit MSB-first shift register with clear and enable.

Test Plan:
- R1 = 8'h01 after 3 idle-high cycles, isLong=0 → isFinish rises 3+8 clk after the first sample; r1=8'h01, isError=0, isTimeout=0, payload=0.
- R7 response 40'h01_000001AA, isLong=1, start bit on the first sampled cycle → r1=8'h01, payload=32'h000001AA, isFinish 40 clk after arm+1.
- DO held high for NCR_MAX=64 cycles → isTimeout=1, r1=8'hFF, isFinish=1. Then drop isStart → isFinish=0 next cycle, state IDLE.
- R1 = 8'h05 (illegal command plus idle) → isError=1, r1=8'h05. Keep isStart=1 for 10 extra cycles → isFinish stays 1, and no re-arm until isStart has toggled low and back high.
- Assert rst asynchronously midway through SHIFT (bit 20 of a long response) → outputs return to reset values without a clk edge. A following R1 8'h00 is received correctly.
- Start bit arrives exactly on wait cycle NCR_MAX → treated as a start, not a timeout; R1 8'h00 received with isTimeout=0.
